// File: rtl/cpu_mem_responder.sv
// Unified instruction/data word memory with a streaming boot loader.
// The CPU is held in reset while the loader fills memory from word 0.
// After the last beat the block switches to RUN. In RUN it serves
// combinational fetches and loads, commits aligned in-range stores and
// latches a sticky fault on bad addresses.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_LOAD | loader owns memory, cpu_reset=1, CPU stores ignored
// ST_RUN  | CPU owns memory, loader ignored, left only by reset
module cpu_mem_responder #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  input  logic        mem_write,
  output logic [31:0] read_data,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        cpu_reset,
  output logic        fault,
  output logic [15:0] store_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [0:0]    state;
  logic [AW-1:0] load_ptr;
  logic [31:0]   mem [DEPTH];

  logic          pc_ok;
  logic          dat_ok;
  logic [AW-1:0] pc_idx;
  logic [AW-1:0] dat_idx;
  logic          load_fire;
  logic          load_done;
  logic          store_fire;
  logic          run;

  // An address is usable when it lies below 4*DEPTH and is word aligned.
  assign pc_ok   = (pc[31:AW+2] == '0) && (pc[1:0] == 2'b00);
  assign dat_ok  = (alu_result[31:AW+2] == '0) && (alu_result[1:0] == 2'b00);
  assign pc_idx  = pc[AW+1:2];
  assign dat_idx = alu_result[AW+1:2];

  assign run        = (state == ST_RUN);
  assign load_ready = !run;
  assign cpu_reset  = !run;
  assign load_fire  = load_valid && load_ready;
  assign load_done  = load_last || (load_ptr == LAST_IDX);
  assign store_fire = run && mem_write && dat_ok;

  // Combinational read ports; a same-edge store only shows up after the edge.
  always_comb begin
    instr     = pc_ok  ? mem[pc_idx]  : 32'h0;
    read_data = dat_ok ? mem[dat_idx] : 32'h0;
  end

  // Memory write port, shared by loader beats and CPU stores. The two are
  // exclusive by state. A reset that precedes the edge forces LOAD, which
  // already blocks any store. Contents survive reset.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem[load_ptr] <= load_data;
    end else if (store_fire) begin
      mem[dat_idx] <= write_data;
    end
  end

  // Sequencing state, load pointer, sticky fault and store counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_LOAD;
      load_ptr    <= '0;
      fault       <= 1'b0;
      store_count <= 16'h0;
    end else begin
      if (load_fire) begin
        if (load_done) begin
          state <= ST_RUN;
        end else begin
          load_ptr <= load_ptr + AW'(1);
        end
      end
      if (run && ((mem_write && !dat_ok) || !pc_ok)) begin
        fault <= 1'b1;
      end
      if (store_fire && (store_count != 16'hffff)) begin
        store_count <= store_count + 16'h1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder. A reference word array
// tracks what the loader and committed stores should have written.
// Expected read values are queued when an address is driven and are
// popped when the combinational output is sampled.
module tb_cpu_mem_responder;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] instr;
  logic [31:0] alu_result = '0;
  logic [31:0] write_data = '0;
  logic        mem_write = 1'b0;
  logic [31:0] read_data;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic        cpu_reset;
  logic        fault;
  logic [15:0] store_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] sb_q [$];
  logic [31:0] sb_exp;
  int          m_ptr = 0;
  bit          m_run = 1'b0;

  cpu_mem_responder #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .instr       (instr),
    .alu_result  (alu_result),
    .write_data  (write_data),
    .mem_write   (mem_write),
    .read_data   (read_data),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .cpu_reset   (cpu_reset),
    .fault       (fault),
    .store_count (store_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_run = 1'b0;
  endtask

  task automatic load_beat(input logic [31:0] data, input logic last);
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    if (!m_run) begin
      ref_mem[m_ptr] = data;
      if (last || m_ptr == DEPTH - 1) m_run = 1'b1;
      else m_ptr++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #2;
    n_tests++;
    if (load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_load_ready: got %b expected 1", load_ready); end
    n_tests++;
    if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_reset: got %b expected 1", cpu_reset); end
    n_tests++;
    if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b expected 0", fault); end
    n_tests++;
    if (store_count !== 16'h0) begin n_fail++; $display("FAIL reset_store_count: got %h expected 0000", store_count); end
    reset = 1'b0;
    model_reset();
    pc         = 32'h3;
    alu_result = 32'hff;
    write_data = 32'h7;
    mem_write  = 1'b1;
    tick();
    tick();
    mem_write  = 1'b0;
    n_tests++;
    if (fault !== 1'b0) begin n_fail++; $display("FAIL load_no_fault: got %b expected 0", fault); end
    n_tests++;
    if (store_count !== 16'h0) begin n_fail++; $display("FAIL load_store_ignored: got %h expected 0000", store_count); end
    n_tests++;
    if (load_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready_held: got %b expected 1", load_ready); end
    pc         = 32'h0;
    alu_result = 32'h0;
  endtask

  task automatic test_load_basic();
    load_beat(32'hE0800001, 1'b0);
    load_beat(32'hE0411002, 1'b0);
    n_tests++;
    if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL basic_cpu_reset_pre: got %b expected 1", cpu_reset); end
    load_beat(32'hE1A00000, 1'b1);
    n_tests++;
    if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL basic_cpu_reset_post: got %b expected 0", cpu_reset); end
    n_tests++;
    if (load_ready !== 1'b0) begin n_fail++; $display("FAIL basic_load_ready: got %b expected 0", load_ready); end
    sb_q.push_back(32'hE0800001);
    sb_q.push_back(32'hE0411002);
    sb_q.push_back(32'hE1A00000);
    for (int i = 0; i < 3; i++) begin
      pc = 32'(4 * i);
      #1;
      sb_exp = sb_q.pop_front();
      n_tests++;
      if (instr !== sb_exp) begin n_fail++; $display("FAIL basic_instr[%0d]: got %h expected %h", i, instr, sb_exp); end
    end
    pc = 32'h0;
    tick();
    n_tests++;
    if (fault !== 1'b0) begin n_fail++; $display("FAIL basic_fault: got %b expected 0", fault); end
  endtask

  task automatic test_store_fault();
    alu_result = 32'hff;
    write_data = 32'h7;
    mem_write  = 1'b1;
    tick();
    mem_write  = 1'b0;
    n_tests++;
    if (fault !== 1'b1) begin n_fail++; $display("FAIL misaligned_fault: got %b expected 1", fault); end
    n_tests++;
    if (store_count !== 16'h0) begin n_fail++; $display("FAIL misaligned_count: got %h expected 0000", store_count); end
    for (int i = 0; i < 3; i++) sb_q.push_back(ref_mem[i]);
    for (int i = 0; i < 3; i++) begin
      alu_result = 32'(4 * i);
      #1;
      sb_exp = sb_q.pop_front();
      n_tests++;
      if (read_data !== sb_exp) begin n_fail++; $display("FAIL misaligned_unchanged[%0d]: got %h expected %h", i, read_data, sb_exp); end
    end
    alu_result = 32'hfc;
    write_data = 32'h7;
    mem_write  = 1'b1;
    tick();
    mem_write  = 1'b0;
    ref_mem[63] = 32'h7;
    sb_q.push_back(ref_mem[63]);
    sb_q.push_back(ref_mem[63]);
    sb_exp = sb_q.pop_front();
    n_tests++;
    if (read_data !== sb_exp) begin n_fail++; $display("FAIL store_read: got %h expected %h", read_data, sb_exp); end
    n_tests++;
    if (store_count !== 16'h1) begin n_fail++; $display("FAIL store_count1: got %h expected 0001", store_count); end
    pc = 32'hfc;
    #1;
    sb_exp = sb_q.pop_front();
    n_tests++;
    if (instr !== sb_exp) begin n_fail++; $display("FAIL store_instr: got %h expected %h", instr, sb_exp); end
    pc = 32'h0;
  endtask

  task automatic test_same_cycle();
    alu_result = 32'h4;
    write_data = 32'hffffffff;
    mem_write  = 1'b1;
    sb_q.push_back(ref_mem[1]);
    #1;
    sb_exp = sb_q.pop_front();
    n_tests++;
    if (read_data !== sb_exp) begin n_fail++; $display("FAIL same_cycle_old: got %h expected %h", read_data, sb_exp); end
    tick();
    mem_write  = 1'b0;
    ref_mem[1] = 32'hffffffff;
    sb_q.push_back(ref_mem[1]);
    sb_exp = sb_q.pop_front();
    n_tests++;
    if (read_data !== sb_exp) begin n_fail++; $display("FAIL same_cycle_new: got %h expected %h", read_data, sb_exp); end
    n_tests++;
    if (store_count !== 16'h2) begin n_fail++; $display("FAIL same_cycle_count: got %h expected 0002", store_count); end
  endtask

  task automatic test_reset_blocks_store();
    alu_result = 32'h0;
    write_data = 32'h12345678;
    mem_write  = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    sb_q.push_back(ref_mem[0]);
    sb_exp = sb_q.pop_front();
    n_tests++;
    if (read_data !== sb_exp) begin n_fail++; $display("FAIL reset_blocks_store: got %h expected %h", read_data, sb_exp); end
    n_tests++;
    if (store_count !== 16'h0) begin n_fail++; $display("FAIL reset_clears_count: got %h expected 0000", store_count); end
    n_tests++;
    if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL reset_forces_load: got %b expected 1", cpu_reset); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic test_mid_load_reset();
    load_beat(32'h11111111, 1'b0);
    n_tests++;
    if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL midload_cpu_reset_b1: got %b expected 1", cpu_reset); end
    load_beat(32'h22222222, 1'b0);
    n_tests++;
    if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL midload_cpu_reset_b2: got %b expected 1", cpu_reset); end
    @(negedge clk);
    reset = 1'b1;
    #2;
    n_tests++;
    if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL midload_cpu_reset_rst: got %b expected 1", cpu_reset); end
    reset = 1'b0;
    model_reset();
    tick();
    n_tests++;
    if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL midload_cpu_reset_post: got %b expected 1", cpu_reset); end
    load_beat(32'h33333333, 1'b1);
    n_tests++;
    if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL midload_run: got %b expected 0", cpu_reset); end
    for (int i = 0; i < 3; i++) sb_q.push_back(ref_mem[i]);
    for (int i = 0; i < 3; i++) begin
      pc = 32'(4 * i);
      #1;
      sb_exp = sb_q.pop_front();
      n_tests++;
      if (instr !== sb_exp) begin n_fail++; $display("FAIL midload_instr[%0d]: got %h expected %h", i, instr, sb_exp); end
    end
    pc = 32'h0;
  endtask

  task automatic test_full_load();
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      load_beat(32'hA5000000 + 32'(i), 1'b0);
      if (i == DEPTH - 2) begin
        n_tests++;
        if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL full_cpu_reset_pre: got %b expected 1", cpu_reset); end
      end
    end
    n_tests++;
    if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL full_cpu_reset_post: got %b expected 0", cpu_reset); end
    n_tests++;
    if (load_ready !== 1'b0) begin n_fail++; $display("FAIL full_load_ready: got %b expected 0", load_ready); end
    load_beat(32'hDEADBEEF, 1'b1);
    sb_q.push_back(ref_mem[0]);
    sb_q.push_back(ref_mem[32]);
    sb_q.push_back(ref_mem[DEPTH-1]);
    for (int i = 0; i < 3; i++) begin
      pc = (i == 0) ? 32'h0 : (i == 1) ? 32'd128 : 32'(4 * (DEPTH - 1));
      #1;
      sb_exp = sb_q.pop_front();
      n_tests++;
      if (instr !== sb_exp) begin n_fail++; $display("FAIL full_instr[%0d]: got %h expected %h", i, instr, sb_exp); end
    end
    pc = 32'h0;
    tick();
    n_tests++;
    if (fault !== 1'b0) begin n_fail++; $display("FAIL full_fault: got %b expected 0", fault); end
  endtask

  task automatic test_pc_fault();
    alu_result = 32'h2;
    sb_q.push_back(32'h0);
    #1;
    sb_exp = sb_q.pop_front();
    n_tests++;
    if (read_data !== sb_exp) begin n_fail++; $display("FAIL misaligned_read: got %h expected %h", read_data, sb_exp); end
    alu_result = 32'h0;
    pc = 32'(4 * DEPTH);
    sb_q.push_back(32'h0);
    #1;
    sb_exp = sb_q.pop_front();
    n_tests++;
    if (instr !== sb_exp) begin n_fail++; $display("FAIL pc_oob_instr: got %h expected %h", instr, sb_exp); end
    tick();
    n_tests++;
    if (fault !== 1'b1) begin n_fail++; $display("FAIL pc_oob_fault: got %b expected 1", fault); end
    pc = 32'h0;
    tick();
    tick();
    n_tests++;
    if (fault !== 1'b1) begin n_fail++; $display("FAIL pc_fault_sticky: got %b expected 1", fault); end
    sb_q.push_back(ref_mem[0]);
    sb_exp = sb_q.pop_front();
    n_tests++;
    if (instr !== sb_exp) begin n_fail++; $display("FAIL pc_return_instr: got %h expected %h", instr, sb_exp); end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 'x;
    #1;
    test_reset();
    test_load_basic();
    test_store_fault();
    test_same_cycle();
    test_reset_blocks_store();
    test_mid_load_reset();
    test_full_load();
    test_pc_fault();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_mem_responder.md
CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, memory size in 32-bit words; power of two, 4..1024.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port pc  input  32  CPU instruction fetch byte address.
REQ-005 SHALL have port instr  output  32  fetched instruction word.
REQ-006 SHALL have port alu_result  input  32  CPU data byte address.
REQ-007 SHALL have port write_data  input  32  CPU store data.
REQ-008 SHALL have port mem_write  input  1  CPU store strobe.
REQ-009 SHALL have port read_data  output  32  CPU load data.
REQ-010 SHALL have port load_valid  input  1  loader beat valid.
REQ-011 SHALL have port load_data  input  32  loader word.
REQ-012 SHALL have port load_last  input  1  marks final loader beat.
REQ-013 SHALL have port load_ready  output  1  block accepts loader beat.
REQ-014 SHALL have port cpu_reset  output  1  holds the CPU in reset while loading.
REQ-015 SHALL have port fault  output  1  sticky error flag.
REQ-016 SHALL have port store_count  output  16  number of committed CPU stores.

Function
REQ-017 SHALL implement one unified word array mem[DEPTH] shared by fetch and data ports.
REQ-018 SHALL index words by address bits [log2(DEPTH)+1:2]; address in range iff address < 4*DEPTH.
REQ-019 SHALL have two states: LOAD, RUN.
REQ-020 LOAD: load_ready=1, cpu_reset=1, a beat is accepted when load_valid&load_ready at posedge.
REQ-021 Accepted beat SHALL write load_data to mem[load_ptr] and increment load_ptr by 1.
REQ-022 Accepted beat with load_last=1, or with load_ptr=DEPTH-1, SHALL move the state to RUN on that same edge; load_ptr then stays unchanged.
REQ-023 RUN: load_ready=0, cpu_reset=0; loader inputs are ignored; RUN is left only by reset.
REQ-024 instr SHALL be combinational mem[pc index] when pc is in range and word-aligned, else 32'h0; it is valid in both states.
REQ-025 read_data SHALL be combinational mem[alu_result index] under the same range/alignment rules, else 32'h0.
REQ-026 Store SHALL commit at posedge iff state=RUN, mem_write=1, alu_result in range, alu_result[1:0]=0; it writes write_data.
REQ-027 A committed store SHALL be visible on read_data/instr combinationally after that edge (write-then-read in the next cycle).
REQ-028 Same-cycle store and read of the same word SHALL return the old word before the edge.
REQ-029 mem_write=1 in RUN with an out-of-range or misaligned alu_result SHALL drop the store and set fault.
REQ-030 pc out of range or misaligned in RUN SHALL set fault; in LOAD the pc check is disabled.
REQ-031 mem_write=1 in LOAD SHALL be ignored and SHALL NOT set fault.
REQ-032 store_count SHALL increment by 1 per committed store and saturate at 16'hffff.
REQ-033 fault SHALL stay set until reset.

Reset
REQ-034 Reset assertion SHALL immediately force state=LOAD, load_ptr=0, load_ready=1, cpu_reset=1, fault=0, store_count=0.
REQ-035 Reset SHALL NOT clear mem contents; a reset mid-load restarts loading at word 0.
REQ-036 Reset asserted on a store edge SHALL block that store.

Verification
REQ-037 Load 3 beats 32'hE0800001, 32'hE0411002, 32'hE1A00000 (last on 3rd) -> cpu_reset falls after the 3rd edge, pc=8 gives instr=32'hE1A00000, load_ready=0.
REQ-038 Load DEPTH beats with load_last=0 -> RUN entered on beat DEPTH-1, beat DEPTH not accepted, mem[DEPTH-1] holds the last word.
REQ-039 RUN: mem_write=1, alu_result=32'hff, write_data=7 -> fault=1, store_count=0, no word changed; then alu_result=32'hfc -> next cycle read_data=7, store_count=1.
REQ-040 RUN: alu_result=32'h4, mem_write=1, write_data=32'hffffffff -> read_data=old mem[1] before the edge, 32'hffffffff after it.
REQ-041 Reset pulse after 2 accepted beats -> load_ptr=0, next beat overwrites mem[0], cpu_reset=1 throughout.
REQ-042 pc=4*DEPTH in RUN -> instr=0, fault=1 remains set after pc returns to 0.
